// File: rtl/fb_axi_writer.sv
// AXI4 write master: streams FB_BEATS 32-bit pixel words into a framebuffer as INCR bursts,
// keeping exactly one burst outstanding at a time.
module fb_axi_writer #(
  parameter int unsigned FB_BEATS  = 307200,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ID        = 0
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] fbAddr,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  output logic [3:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [3:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam int unsigned REM_W = $clog2(FB_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t           state;
  logic [REM_W-1:0] remaining;
  logic [7:0]       beat_cnt;
  logic             beat_hs;
  logic             unused_bid;

  // awlen for the next burst: full BURST_LEN, or whatever is left for the tail burst
  function automatic logic [7:0] burst_awlen(input logic [REM_W-1:0] rem);
    if (32'(rem) >= BURST_LEN) return 8'(BURST_LEN - 32'd1);
    else                       return 8'(32'(rem) - 32'd1);
  endfunction

  assign m_axi_awid    = 4'(ID);
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'd1;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = 4'hF;
  assign unused_bid    = ^m_axi_bid;

  // W channel is a zero-latency pass-through of the pixel stream, gated to the DATA phase
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wvalid  = (state == S_DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == S_DATA) && m_axi_wready;
  assign m_axi_wlast   = (state == S_DATA) && (beat_cnt == 8'd0);
  assign beat_hs       = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_axi_awaddr  <= fbAddr;
            m_axi_awlen   <= burst_awlen(REM_W'(FB_BEATS));
            m_axi_awvalid <= 1'b1;
            remaining     <= REM_W'(FB_BEATS);
            error         <= 1'b0;
            busy          <= 1'b1;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat_cnt      <= m_axi_awlen;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_hs) begin
            beat_cnt  <= beat_cnt - 8'd1;
            remaining <= remaining - REM_W'(1);
            if (beat_cnt == 8'd0) begin
              m_axi_bready <= 1'b1;
              state        <= S_RESP;
            end
          end
        end
        S_RESP: begin
          // next burst is issued only after this one's write response
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            error        <= error | (m_axi_bresp != 2'b00);
            m_axi_awaddr <= m_axi_awaddr + ((32'(m_axi_awlen) + 32'd1) << 2);
            if (remaining == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              m_axi_awlen   <= burst_awlen(remaining);
              m_axi_awvalid <= 1'b1;
              state         <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_axi_writer.sv
// Scoreboard bench for fb_axi_writer: 36-word frames in 16-beat bursts (16+16+4),
// AXI slave with optional stalls, response errors, start-while-busy and mid-burst reset.
module tb_fb_axi_writer;

  localparam int unsigned FB = 36;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] fbAddr = 32'd0;
  logic        busy, done, error;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'd0;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [3:0]  m_axi_bid = 4'd0;
  logic [1:0]  m_axi_bresp = 2'd0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  fb_axi_writer #(.FB_BEATS(FB), .BURST_LEN(16), .ID(5)) u_dut (
    .aclk(aclk), .resetn(resetn), .start(start), .fbAddr(fbAddr),
    .busy(busy), .done(done), .error(error),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int w_cnt = 0;
  int b_pend = 0;
  logic stall = 1'b0;
  logic gaps = 1'b0;

  logic [39:0] aw_exp[$];   // {awaddr, awlen}
  logic [32:0] w_exp[$];    // {wlast, wdata}
  logic        done_exp[$]; // error expected when done pulses
  logic [31:0] src_q[$];
  logic [1:0]  resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Expected traffic for one 36-word frame: bursts of 16, 16 and 4 beats
  task automatic push_frame(input logic [31:0] base, input logic [31:0] dbase, input logic exp_err);
    aw_exp.push_back({base,             8'd15});
    aw_exp.push_back({base + 32'h40,    8'd15});
    aw_exp.push_back({base + 32'h80,    8'd3});
    for (int i = 0; i < int'(FB); i++) begin
      src_q.push_back(dbase + 32'(i));
      w_exp.push_back({(i == 15 || i == 31 || i == 35), dbase + 32'(i)});
    end
    done_exp.push_back(exp_err);
  endtask

  task automatic pulse_start(input logic [31:0] addr);
    @(posedge aclk); #1;
    fbAddr = addr;
    start  = 1'b1;
    @(posedge aclk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 4000) begin
      @(negedge aclk); #1;
      n++;
    end
    chk("frame_done_count", 32'(done_cnt), 32'(target));
  endtask

  // Pixel stream source; tvalid held until accepted
  initial begin
    logic hs;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk); #1;
      if (!resetn) begin
        src_q.delete();
        s_axis_tvalid = 1'b0;
      end else begin
        if (hs) begin
          void'(src_q.pop_front());
          s_axis_tvalid = 1'b0;
        end
        if (!s_axis_tvalid && src_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = src_q[0];
        end
      end
    end
  end

  // AXI slave: AW/W ready (optionally random), one B per completed burst
  initial begin
    logic wl_hs, b_hs;
    forever begin
      @(negedge aclk);
      wl_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
      b_hs  = m_axi_bvalid && m_axi_bready;
      @(posedge aclk); #1;
      if (!resetn) begin
        b_pend = 0;
        m_axi_bvalid = 1'b0;
      end else begin
        if (b_hs) m_axi_bvalid = 1'b0;
        if (wl_hs) b_pend++;
        if (!m_axi_bvalid && b_pend > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'd0;
          b_pend--;
        end
      end
      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake or pulses done
  initial begin
    logic        aw_stall = 1'b0;
    logic [31:0] hold_addr = 32'd0;
    logic [7:0]  hold_len = 8'd0;
    logic [39:0] ea;
    logic [32:0] ew;
    logic        ee;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        aw_stall = 1'b0;
        continue;
      end
      if (m_axi_awvalid) begin
        if (aw_stall) begin
          chk("aw_stable_addr", m_axi_awaddr, hold_addr);
          chk("aw_stable_len", 32'(m_axi_awlen), 32'(hold_len));
        end
        if (m_axi_awready) begin
          aw_stall = 1'b0;
          if (aw_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected actual=%h/%0d required=none @%0t", m_axi_awaddr, m_axi_awlen, $time);
          end else begin
            ea = aw_exp.pop_front();
            chk("awaddr", m_axi_awaddr, ea[39:8]);
            chk("awlen", 32'(m_axi_awlen), 32'(ea[7:0]));
          end
        end else begin
          aw_stall  = 1'b1;
          hold_addr = m_axi_awaddr;
          hold_len  = m_axi_awlen;
        end
      end else begin
        aw_stall = 1'b0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_cnt++;
        chk("tready_passthru", 32'(s_axis_tready), 32'd1);
        if (w_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected actual=%h required=none @%0t", m_axi_wdata, $time);
        end else begin
          ew = w_exp.pop_front();
          chk("wdata", m_axi_wdata, ew[31:0]);
          chk("wlast", 32'(m_axi_wlast), 32'(ew[32]));
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 32'd0);
        if (done_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=1 required=0 @%0t", $time);
        end else begin
          ee = done_exp.pop_front();
          chk("error_at_done", 32'(error), 32'(ee));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // reset values and constant fields
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_wlast", 32'(m_axi_wlast), 32'd0);
    chk("rst_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_awlen", 32'(m_axi_awlen), 32'd0);
    chk("awid", 32'(m_axi_awid), 32'd5);
    chk("awsize", 32'(m_axi_awsize), 32'd2);
    chk("awburst", 32'(m_axi_awburst), 32'd1);
    chk("wstrb", 32'(m_axi_wstrb), 32'hF);
    @(negedge aclk);
    resetn = 1'b1;

    // frame 1: no stalls
    push_frame(32'h01E0_0000, 32'h0000_0000, 1'b0);
    pulse_start(32'h01E0_0000);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(1);

    // frame 2: random stream gaps and slave stalls
    stall = 1'b1;
    gaps  = 1'b1;
    push_frame(32'h0200_0000, 32'h0000_0100, 1'b0);
    pulse_start(32'h0200_0000);
    wait_done(2);
    stall = 1'b0;
    gaps  = 1'b0;

    // frame 3: SLVERR on the second burst, transfer still completes
    resp_q.push_back(2'd0);
    resp_q.push_back(2'd2);
    resp_q.push_back(2'd0);
    push_frame(32'h0210_0000, 32'h0000_0200, 1'b1);
    pulse_start(32'h0210_0000);
    wait_done(3);
    chk("error_sticky", 32'(error), 32'd1);

    // frame 4: start clears error; a start while busy is ignored
    push_frame(32'h0220_0000, 32'h0000_0300, 1'b0);
    pulse_start(32'h0220_0000);
    chk("error_cleared", 32'(error), 32'd0);
    repeat (10) @(negedge aclk);
    pulse_start(32'h0BAD_0000);
    wait_done(4);
    repeat (30) @(negedge aclk);
    #1;
    chk("idle_after_ignored_start", 32'(busy), 32'd0);

    // frame 5: reset while beat 5 of the first burst is on the bus
    push_frame(32'h0300_0000, 32'h0000_0400, 1'b0);
    w0 = w_cnt;
    pulse_start(32'h0300_0000);
    for (int n = 0; n < 200 && (w_cnt - w0) < 4; n++) begin
      @(negedge aclk); #1;
    end
    chk("beat5_wvalid", 32'(m_axi_wvalid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_mid_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_mid_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge aclk);
    #2;
    aw_exp.delete();
    w_exp.delete();
    done_exp.delete();
    src_q.delete();
    resp_q.delete();
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    resetn = 1'b1;

    // frame 6: fresh start after reset writes from the new base with a full first burst
    push_frame(32'h0400_0000, 32'h0000_0500, 1'b0);
    pulse_start(32'h0400_0000);
    wait_done(5);
    repeat (10) @(negedge aclk);
    chk("aw_queue_empty", 32'(aw_exp.size()), 32'd0);
    chk("w_queue_empty", 32'(w_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
